// File: rtl/console_tx_port.sv
// Memory-mapped console transmitter: CPU stores queue bytes in a FIFO, emitted as one-cycle strobes.
// Optional build macro CONSOLE_TX_EOT_LOCK_EN: stop accepting/emitting after a 0x00 byte is popped.
module console_tx_port #(
  parameter int          DEPTH     = 8,
  parameter int          GAP       = 2,
  parameter logic [31:0] DATA_ADDR = 32'hFFFF_0000,
  parameter logic [31:0] STAT_ADDR = 32'hFFFF_0004
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [7:0]  value,
  output logic        interrupt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          full, empty, busy, wr_hit;
  logic          push, pop, can_pop, ovf, ovf_set, locked;
  logic [7:0]    head;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    value_n;
  logic          interrupt_n;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign busy   = !empty || (state != IDLE);
  assign head   = mem[rptr[AW-1:0]];
  assign wr_hit = we && (addr == DATA_ADDR);

  // full is taken before any same-cycle pop, so a store into a full FIFO is dropped.
  assign push    = wr_hit && !full && !locked;
  assign ovf_set = wr_hit && full && !locked;
  assign can_pop = !empty && !locked;

`ifdef CONSOLE_TX_EOT_LOCK_EN
  logic lock;
  always_ff @(posedge clk) begin
    if (!reset_n)                  lock <= 1'b0;
    else if (pop && head == 8'h00) lock <= 1'b1;
  end
  assign locked = lock;
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    value_n     = value;
    interrupt_n = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: if (can_pop) begin
        pop         = 1'b1;
        value_n     = head;
        interrupt_n = 1'b1;
        state_n     = EMIT;
      end
      EMIT: begin
        if (GAP == 0) begin
          if (can_pop) begin
            pop         = 1'b1;
            value_n     = head;
            interrupt_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = WAIT;
          cnt_n   = CW'(GAP - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      value     <= 8'h00;
      interrupt <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      value     <= value_n;
      interrupt <= interrupt_n;
      if (push)    wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (ovf_set) ovf  <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata[7:0];
  end

  always_comb begin
    rdata = '0;
    if (addr == STAT_ADDR) rdata[3:0] = {locked, ovf, full, busy};
  end

endmodule

// File: tb/tb_console_tx_port.sv
// Scoreboard bench for console_tx_port: expected bytes are queued at stimulus time, monitors pop on strobes.
module tb_console_tx_port;

  localparam logic [31:0] DATA = 32'hFFFF_0000;
  localparam logic [31:0] STAT = 32'hFFFF_0004;
  localparam int GAP  = 2;
  localparam int GAP2 = 12;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr, wdata, rdata;
  logic        we;
  logic [7:0]  value;
  logic        interrupt;
  logic [31:0] addr2, wdata2, rdata2;
  logic        we2;
  logic [7:0]  value2;
  logic        interrupt2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_q2[$];

  always #5 clk = ~clk;

  console_tx_port #(.DEPTH(8), .GAP(GAP)) u_dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .value(value), .interrupt(interrupt)
  );

  console_tx_port #(.DEPTH(8), .GAP(GAP2)) u_big (
    .clk(clk), .reset_n(reset_n), .addr(addr2), .wdata(wdata2), .we(we2),
    .rdata(rdata2), .value(value2), .interrupt(interrupt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: compare each strobe with the scoreboard and enforce the idle gap.
  int  last1, last2;
  bit  have1 = 0, have2 = 0;

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      have1 = 0;
      have2 = 0;
    end
  end

  always @(negedge clk) begin
    if (interrupt === 1'b1) begin
      if (exp_q.size() == 0) check("main_unexpected_strobe", {24'h0, value}, 32'hFFFF_FFFF);
      else                   check("main_strobe_value", {24'h0, value}, {24'h0, exp_q.pop_front()});
      if (have1) check("main_gap", 32'(cyc - last1 >= GAP + 1), 32'd1);
      last1 = cyc;
      have1 = 1;
    end
    if (interrupt2 === 1'b1) begin
      if (exp_q2.size() == 0) check("big_unexpected_strobe", {24'h0, value2}, 32'hFFFF_FFFF);
      else                    check("big_strobe_value", {24'h0, value2}, {24'h0, exp_q2.pop_front()});
      if (have2) check("big_gap", 32'(cyc - last2 >= GAP2 + 1), 32'd1);
      last2 = cyc;
      have2 = 1;
    end
  end

  task automatic drive(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = {24'hABCDEF, d}; we = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    we = 1'b0; addr = STAT;
    #1;
  endtask

  task automatic drive2(input logic [7:0] d);
    @(negedge clk);
    addr2 = DATA; wdata2 = {24'h0, d}; we2 = 1'b1;
  endtask

  task automatic idle2();
    @(negedge clk);
    we2 = 1'b0; addr2 = STAT;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; we = 1'b0; we2 = 1'b0; addr = STAT; addr2 = STAT;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; we = 1'b0; we2 = 1'b0;
    addr = STAT; addr2 = STAT; wdata = '0; wdata2 = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_interrupt", {31'h0, interrupt}, 32'h0);
    check("reset_value", {24'h0, value}, 32'h0);
    check("reset_status", rdata, 32'h0);
    check("reset_status_big", rdata2, 32'h0);

    // Single byte: strobe one edge after the write, busy clears after the gap.
    exp_q.push_back(8'h48);
    drive(DATA, 8'h48);
    idle();
    check("t1_busy_after_push", rdata, 32'h1);
    idle();
    check("t1_strobe_high", {31'h0, interrupt}, 32'h1);
    check("t1_strobe_value", {24'h0, value}, 32'h48);
    idle();
    check("t1_strobe_one_cycle", {31'h0, interrupt}, 32'h0);
    check("t1_busy_wait1", rdata, 32'h1);
    addr = DATA; #1;
    check("t1_rdata_other_addr", rdata, 32'h0);
    idle();
    check("t1_busy_wait2", rdata, 32'h1);
    idle();
    check("t1_busy_clear", rdata, 32'h0);

    // Back-to-back string with end-of-stream marker.
    foreach (exp_q2[i]) ; // keep second queue untouched here
    exp_q.push_back(8'h48); exp_q.push_back(8'h69);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h00);
    drive(DATA, 8'h48); drive(DATA, 8'h69); drive(DATA, 8'h0A); drive(DATA, 8'h00);
    repeat (20) idle();
    check("t2_all_emitted", exp_q.size(), 32'd0);
    do_reset();

    // Stores to other addresses are ignored.
    drive(DATA + 32'd4, 8'h5A);
    drive(32'h0, 8'h59);
    repeat (6) idle();
    check("t4_status_empty", rdata, 32'h0);

    // Overflow on the long-gap instance: b0 popped at N+1, b1..b8 fill it, b9 dropped.
    exp_q2.push_back(8'h10);
    exp_q2.push_back(8'h11);
    for (int i = 0; i < 10; i++) drive2(8'h10 + 8'(i));
    idle2();
    check("t3_status_ovf_full_busy", rdata2, 32'h7);
    repeat (4) idle2();
    drive2(8'hEE);  // lands on the pop edge N+15 while full
    idle2();
    check("t3_pop_strobe", {31'h0, interrupt2}, 32'h1);
    check("t3_push_on_pop_dropped", rdata2, 32'h5);
    repeat (3) idle2();
    do_reset();
    check("t3_reset_interrupt", {31'h0, interrupt2}, 32'h0);
    check("t3_reset_value", {24'h0, value2}, 32'h0);
    check("t3_reset_clears_ovf", rdata2, 32'h0);
    repeat (20) idle2();
    check("t3_no_more_strobes", exp_q2.size(), 32'd0);

    // Reset in WAIT with three bytes queued aborts the stream.
    exp_q.push_back(8'h31);
    drive(DATA, 8'h31); drive(DATA, 8'h32); drive(DATA, 8'h33); drive(DATA, 8'h34);
    do_reset();
    check("t5_reset_interrupt", {31'h0, interrupt}, 32'h0);
    check("t5_reset_value", {24'h0, value}, 32'h0);
    repeat (12) idle();
    check("t5_status_clear", rdata, 32'h0);
    check("t5_only_first_emitted", exp_q.size(), 32'd0);

    // End-of-stream lock behaviour.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h00);
`ifndef CONSOLE_TX_EOT_LOCK_EN
    exp_q.push_back(8'h42);
`endif
    drive(DATA, 8'h41); drive(DATA, 8'h00); drive(DATA, 8'h42);
    repeat (20) idle();
`ifdef CONSOLE_TX_EOT_LOCK_EN
    check("t6_status_locked", rdata, 32'h9);
`else
    check("t6_status_idle", rdata, 32'h0);
`endif
    check("t6_all_emitted", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
